fir_coef_bank_ctrl: RTL and testbench

Runtime coefficient configuration controller for the 63-tap Q5.27 FIR datapath. It holds two coefficient banks, active and shadow. A host streams a full 63-word coefficient set into the shadow bank over a valid/ready interface. The controller swaps banks only on a FIR sample boundary, so the filter never computes an output from a mixed coefficient set. It sits between the host/config bus and the FIR datapath's coefficient inputs, replacing the static file-loaded coefficient ROM.

---
 rtl/fir_coef_bank_ctrl_if.sv | 20 ++
 rtl/fir_coef_bank_ctrl.sv | 92 +++++++++
 tb/tb_fir_coef_bank_ctrl.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_coef_bank_ctrl_if.sv
// Host-side coefficient load channel: start/abort control plus a valid/ready word stream.
interface fir_coef_bank_ctrl_if #(
  parameter int COEF_W = 32
);
  logic              cfg_start;
  logic              cfg_valid;
  logic [COEF_W-1:0] cfg_data;
  logic              cfg_ready;
  logic              cfg_abort;

  modport master (
    output cfg_start, cfg_valid, cfg_data, cfg_abort,
    input  cfg_ready
  );

  modport slave (
    input  cfg_start, cfg_valid, cfg_data, cfg_abort,
    output cfg_ready
  );
endinterface

// File: rtl/fir_coef_bank_ctrl.sv
// Double-buffered FIR coefficient store: the host fills the shadow bank, and the banks
// swap only on a sample_tick so the filter never sees a mixed coefficient set.
module fir_coef_bank_ctrl #(
  parameter int TAPS   = 63,
  parameter int COEF_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  fir_coef_bank_ctrl_if.slave      cfg,
  input  logic                     sample_tick,
  output logic [TAPS*COEF_W-1:0]   coef_flat,
  output logic                     bank_sel,
  output logic [CNT_W-1:0]         word_cnt,
  output logic                     busy,
  output logic                     load_done,
  output logic                     load_err
);

  typedef enum logic [1:0] {IDLE, LOAD, ARMED} state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TAPS - 1);

  state_t            state;
  logic [COEF_W-1:0] bank [2][TAPS];

  assign cfg.cfg_ready = (state == LOAD) && !cfg.cfg_abort;
  assign busy          = (state != IDLE);

  // The active bank is only ever read; all writes target the shadow bank.
  always_comb begin
    coef_flat = '0;
    for (int k = 0; k < TAPS; k++) begin
      coef_flat[k*COEF_W +: COEF_W] = bank[bank_sel][k];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      bank_sel  <= 1'b0;
      word_cnt  <= '0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < TAPS; k++) begin
          bank[b][k] <= '0;
        end
      end
    end else begin
      load_done <= 1'b0;
      load_err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cfg.cfg_start) begin
            state    <= LOAD;
            word_cnt <= '0;
          end
        end
        LOAD: begin
          if (cfg.cfg_abort) begin
            state    <= IDLE;
            word_cnt <= '0;
            load_err <= 1'b1;
          end else if (cfg.cfg_valid) begin
            bank[~bank_sel][word_cnt] <= cfg.cfg_data;
            word_cnt                  <= word_cnt + 1'b1;
            if (word_cnt == LAST_IDX) begin
              state <= ARMED;
            end
          end
        end
        ARMED: begin
          // Abort takes priority over a coincident sample_tick, so no swap happens.
          if (cfg.cfg_abort) begin
            state    <= IDLE;
            word_cnt <= '0;
            load_err <= 1'b1;
          end else if (sample_tick) begin
            state     <= IDLE;
            bank_sel  <= ~bank_sel;
            load_done <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_coef_bank_ctrl.sv
// Scoreboard bench for fir_coef_bank_ctrl: stimulus queues expected done/err events,
// a negedge monitor pops and compares them against the DUT pulses.
module tb_fir_coef_bank_ctrl;

  localparam int TAPS   = 63;
  localparam int COEF_W = 32;
  localparam int CNT_W  = 6;

  typedef struct {
    bit                       done;
    bit                       err;
    bit                       sel;
    logic [TAPS*COEF_W-1:0]   coef;
  } exp_t;

  logic                     clk;
  logic                     rst_n;
  logic                     sample_tick;
  logic [TAPS*COEF_W-1:0]   coef_flat;
  logic                     bank_sel;
  logic [CNT_W-1:0]         word_cnt;
  logic                     busy;
  logic                     load_done;
  logic                     load_err;

  fir_coef_bank_ctrl_if #(.COEF_W(COEF_W)) cfg ();

  fir_coef_bank_ctrl #(.TAPS(TAPS), .COEF_W(COEF_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg         (cfg.slave),
    .sample_tick (sample_tick),
    .coef_flat   (coef_flat),
    .bank_sel    (bank_sel),
    .word_cnt    (word_cnt),
    .busy        (busy),
    .load_done   (load_done),
    .load_err    (load_err)
  );

  int          checks = 0;
  int          errors = 0;
  exp_t        expQ[$];
  logic [31:0] loadWords [TAPS];
  logic [31:0] mBank [2][TAPS];
  bit          mSel;
  bit          mArmed;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [TAPS*COEF_W-1:0] flatOf(input bit sel);
    logic [TAPS*COEF_W-1:0] v;
    v = '0;
    for (int k = 0; k < TAPS; k++) v[k*COEF_W +: COEF_W] = mBank[sel][k];
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkCoef(input string name, input logic [TAPS*COEF_W-1:0] exp);
    int bad;
    bad = -1;
    for (int k = TAPS - 1; k >= 0; k--) begin
      if (coef_flat[k*COEF_W +: COEF_W] !== exp[k*COEF_W +: COEF_W]) bad = k;
    end
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("[TB] FAIL %s: tap %0d got %h expected %h", name, bad,
               coef_flat[bad*COEF_W +: COEF_W], exp[bad*COEF_W +: COEF_W]);
    end
  endtask

  task automatic pushEvt(input bit done, input bit err);
    exp_t e;
    e.done = done;
    e.err  = err;
    e.sel  = mSel;
    e.coef = flatOf(mSel);
    expQ.push_back(e);
  endtask

  // Monitor: every done/err pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (load_done || load_err) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_pulse: got done=%0b err=%0b expected none", load_done, load_err);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("evt_done", 64'(load_done), 64'(e.done));
        checkOutput("evt_err", 64'(load_err), 64'(e.err));
        checkOutput("evt_sel", 64'(bank_sel), 64'(e.sel));
        checkCoef("evt_coef", e.coef);
      end
    end
  end

  // Streams loadWords; cutKind 1 aborts at word cutAt, cutKind 2 just stops there.
  task automatic applyStimulus(input int mode, input int cutAt, input int cutKind,
                               input bit tickOnLast, output int iters);
    int idx;
    bit hs;
    iters = 0;
    idx   = 0;
    @(posedge clk); #1 cfg.cfg_start = 1'b1;
    @(posedge clk); #1 cfg.cfg_start = 1'b0;
    checkOutput("start_wcnt", 64'(word_cnt), 64'd0);
    checkOutput("start_busy", 64'(busy), 64'd1);
    while (idx < TAPS && iters < 1000) begin
      if (cutKind != 0 && idx == cutAt) begin
        if (cutKind == 1) begin
          cfg.cfg_abort = 1'b1;
          cfg.cfg_valid = 1'b1;
          cfg.cfg_data  = 32'hDEADBEEF;
          #1 checkOutput("abort_rdy", 64'(cfg.cfg_ready), 64'd0);
          pushEvt(1'b0, 1'b1);
          @(posedge clk); #1;
          cfg.cfg_abort = 1'b0;
          cfg.cfg_valid = 1'b0;
          checkOutput("abort_wcnt", 64'(word_cnt), 64'd0);
          checkOutput("abort_busy", 64'(busy), 64'd0);
        end
        cfg.cfg_valid = 1'b0;
        return;
      end
      cfg.cfg_valid = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      cfg.cfg_data  = loadWords[idx];
      sample_tick   = tickOnLast && (idx == TAPS - 1) && cfg.cfg_valid;
      #1 checkOutput("load_rdy", 64'(cfg.cfg_ready), 64'd1);
      hs = cfg.cfg_valid;
      @(posedge clk); #1;
      sample_tick = 1'b0;
      if (hs) begin
        mBank[!mSel][idx] = loadWords[idx];
        idx++;
      end
      iters++;
    end
    cfg.cfg_valid = 1'b0;
    checkOutput("load_complete", 64'(idx), 64'(TAPS));
    mArmed = 1'b1;
    checkOutput("armed_rdy", 64'(cfg.cfg_ready), 64'd0);
    checkOutput("armed_busy", 64'(busy), 64'd1);
    checkOutput("armed_wcnt", 64'(word_cnt), 64'(TAPS));
  endtask

  task automatic issueTick(input bit withAbort);
    sample_tick   = 1'b1;
    cfg.cfg_abort = withAbort;
    if (mArmed) begin
      if (withAbort) begin
        pushEvt(1'b0, 1'b1);
      end else begin
        mSel = !mSel;
        pushEvt(1'b1, 1'b0);
      end
      mArmed = 1'b0;
    end
    @(posedge clk); #1;
    sample_tick   = 1'b0;
    cfg.cfg_abort = 1'b0;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    cfg.cfg_start = 1'b0;
    cfg.cfg_valid = 1'b0;
    cfg.cfg_abort = 1'b0;
    sample_tick   = 1'b0;
    @(posedge clk); #1;
    for (int b = 0; b < 2; b++) for (int k = 0; k < TAPS; k++) mBank[b][k] = '0;
    mSel   = 1'b0;
    mArmed = 1'b0;
    checkOutput("rst_ready", 64'(cfg.cfg_ready), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_sel", 64'(bank_sel), 64'd0);
    checkOutput("rst_wcnt", 64'(word_cnt), 64'd0);
    checkOutput("rst_done", 64'(load_done), 64'd0);
    checkOutput("rst_err", 64'(load_err), 64'd0);
    checkCoef("rst_coef", '0);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int iters;
    cfg.cfg_data = '0;
    cfg.cfg_start = 1'b0;
    cfg.cfg_valid = 1'b0;
    cfg.cfg_abort = 1'b0;
    sample_tick   = 1'b0;
    rst_n         = 1'b0;
    @(posedge clk); #1;
    doReset();

    $display("[TB] full-rate load of 0x08000000+k");
    for (int k = 0; k < TAPS; k++) loadWords[k] = 32'h08000000 + 32'(k);
    applyStimulus(0, 0, 0, 1'b0, iters);
    checkOutput("t1_iters", 64'(iters), 64'd63);
    cfg.cfg_start = 1'b1;
    @(posedge clk); #1 cfg.cfg_start = 1'b0;
    checkOutput("start_in_armed_busy", 64'(busy), 64'd1);
    checkOutput("start_in_armed_rdy", 64'(cfg.cfg_ready), 64'd0);
    issueTick(1'b0);
    checkOutput("t1_sel", 64'(bank_sel), 64'd1);
    checkOutput("t1_tap62", 64'(coef_flat[62*COEF_W +: COEF_W]), 64'h0800003E);

    $display("[TB] backpressured load");
    for (int k = 0; k < TAPS; k++) loadWords[k] = (32'(k) * 32'h01010101) ^ 32'hA5000000;
    applyStimulus(1, 0, 0, 1'b0, iters);
    issueTick(1'b0);
    checkOutput("t2_sel", 64'(bank_sel), 64'd0);

    $display("[TB] abort after 20 words, then all-ones load");
    for (int k = 0; k < TAPS; k++) loadWords[k] = 32'h55AA0000 + 32'(k);
    applyStimulus(0, 20, 1, 1'b0, iters);
    checkOutput("t3_sel", 64'(bank_sel), 64'd0);
    checkCoef("t3_coef_kept", flatOf(mSel));
    for (int k = 0; k < TAPS; k++) loadWords[k] = 32'hFFFFFFFF;
    applyStimulus(0, 0, 0, 1'b0, iters);
    issueTick(1'b0);
    checkOutput("t3_sel_after", 64'(bank_sel), 64'd1);

    $display("[TB] abort while idle");
    cfg.cfg_abort = 1'b1;
    @(posedge clk); #1 cfg.cfg_abort = 1'b0;
    checkOutput("idle_abort_err", 64'(load_err), 64'd0);

    $display("[TB] sample_tick on final handshake");
    for (int k = 0; k < TAPS; k++) loadWords[k] = 32'h10000000 + 32'(k * 3);
    applyStimulus(0, 0, 0, 1'b1, iters);
    checkOutput("t4_no_swap_sel", 64'(bank_sel), 64'd1);
    issueTick(1'b0);
    checkOutput("t4_sel", 64'(bank_sel), 64'd0);

    $display("[TB] abort with sample_tick while armed");
    for (int k = 0; k < TAPS; k++) loadWords[k] = 32'hC0000000 | 32'(k);
    applyStimulus(0, 0, 0, 1'b0, iters);
    issueTick(1'b1);
    checkOutput("t5_sel", 64'(bank_sel), 64'd0);
    checkOutput("t5_busy", 64'(busy), 64'd0);

    $display("[TB] reset mid-load and while armed");
    for (int k = 0; k < TAPS; k++) loadWords[k] = 32'h7FFFFFF0 - 32'(k);
    applyStimulus(0, 40, 2, 1'b0, iters);
    doReset();
    applyStimulus(0, 0, 0, 1'b0, iters);
    doReset();
    for (int k = 0; k < TAPS; k++) loadWords[k] = 32'h0;
    applyStimulus(0, 0, 0, 1'b0, iters);
    issueTick(1'b0);
    checkOutput("t6_sel1", 64'(bank_sel), 64'd1);
    applyStimulus(0, 0, 0, 1'b0, iters);
    issueTick(1'b0);
    checkOutput("t6_sel0", 64'(bank_sel), 64'd0);

    repeat (4) @(posedge clk);
    #1 checkOutput("queue_drained", 64'(expQ.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
